// File: rtl/button_event_queue.sv
// rtl/button_event_queue.sv - debounced button scanner with press/release event FIFO and CPU read port
//
// Purpose:
//   Round-robin scans N debounced button levels against the last reported
//   level. Each detected transition is queued as an event word. A small
//   register map exposes the levels, the event queue and a status word.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high
//   buttons_in debounced button levels, 1 = pressed
//   rd_en      CPU read strobe, one cycle per access
//   rd_addr    register select (0 levels, 1 pop, 2 status, 3 zero)
//   rd_data    registered read data, valid the cycle after rd_en
//   irq        high while the event FIFO is non-empty
module button_event_queue #(
    parameter int N_BUTTONS  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] buttons_in,
    input  logic                 rd_en,
    input  logic [1:0]           rd_addr,
    output logic [15:0]          rd_data,
    output logic                 irq
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [N_BUTTONS-1:0] reported;
    logic [IDX_WIDTH-1:0] scan_idx;
    logic [15:0]          mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 overflow;

    logic                 cur_level;
    logic                 mismatch;
    logic                 fifo_full;
    logic                 push;
    logic                 pop;
    logic [15:0]          event_word;
    logic [CW-1:0]        count_next;

    always_comb begin
        cur_level  = buttons_in[scan_idx];
        mismatch   = cur_level != reported[scan_idx];
        // Eligibility uses the pre-cycle count: a same-cycle pop never frees a slot for this push.
        fifo_full  = count == CW'(FIFO_DEPTH);
        push       = mismatch && !fifo_full;
        pop        = rd_en && (rd_addr == 2'd1) && (count != '0);
        event_word = {1'b1, cur_level, {(14 - IDX_WIDTH){1'b0}}, scan_idx};
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= event_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reported <= '0;
            scan_idx <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_data  <= '0;
            irq      <= 1'b0;
        end else begin
            // A full-FIFO mismatch leaves reported alone so the event is retried next lap.
            if (push) begin
                reported[scan_idx] <= cur_level;
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            scan_idx <= (scan_idx == IDX_WIDTH'(N_BUTTONS - 1)) ? '0 : scan_idx + 1'b1;
            count    <= count_next;
            irq      <= count_next != '0;

            // Set beats the read-clear so a loss in the clearing cycle is not hidden.
            if (mismatch && fifo_full) begin
                overflow <= 1'b1;
            end else if (rd_en && (rd_addr == 2'd2)) begin
                overflow <= 1'b0;
            end

            if (rd_en) begin
                case (rd_addr)
                    2'd0:    rd_data <= 16'(buttons_in);
                    2'd1:    rd_data <= (count != '0) ? mem[rd_ptr] : 16'h0000;
                    2'd2:    rd_data <= {overflow, 8'h00, 7'(count)};
                    default: rd_data <= 16'h0000;
                endcase
            end
        end
    end

endmodule

// File: doc/button_event_queue.md
Name: button_event_queue

Overview:
Reader-side companion for the per-button debouncers. Collects N debounced button levels and detects press and release transitions with a round-robin scanner. Queues those transitions as events in a small FIFO. Exposes levels, events and status to the CPU through a registered read port (1-cycle latency) mapped into I/O space.

Parameters:
N_BUTTONS, 8, number of debounced inputs (1..16)
FIFO_DEPTH, 8, event queue entries (power of 2, 2..64)
IDX_WIDTH, 4, scanner index width; must satisfy 2**IDX_WIDTH >= N_BUTTONS

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high
buttons_in  input  N_BUTTONS  debounced button levels, 1 = pressed
rd_en  input  1  CPU read strobe, one cycle per access
rd_addr  input  2  register select
rd_data  output  16  registered read data, valid the cycle after rd_en
irq  output  1  high while the FIFO is non-empty

Behaviour:
- Reset: reported[N-1:0]=0, scan_idx=0, FIFO empty (wr_ptr=rd_ptr=count=0), overflow=0, rd_data=0, irq=0. Reset mid-operation discards all queued events.
- Scanner: each cycle compares buttons_in[scan_idx] with reported[scan_idx].
  - Mismatch and count < FIFO_DEPTH (pre-cycle count): push event {press=buttons_in[scan_idx], idx=scan_idx}; reported[scan_idx] <= buttons_in[scan_idx].
  - Mismatch and FIFO full: no push, reported unchanged (event retried next lap), overflow <= 1.
  - scan_idx always advances: N_BUTTONS-1 wraps to 0.
- Coalescing: a button that toggles an even number of times between visits produces no event. Worst-case detect latency is N_BUTTONS cycles.
- Event word: bit15=1 (valid), bit14=press(1)/release(0), bits[IDX_WIDTH-1:0]=index, all other bits 0.
- Read map (rd_data updated only when rd_en=1, else holds):
  - addr 0: buttons_in levels as sampled, zero-extended.
  - addr 1: pop. Non-empty: head event, rd_ptr++, count--. Empty: 0x0000, no state change.
  - addr 2: status {bit15=overflow, bits[6:0]=count}. Reading clears overflow. If a full-FIFO mismatch occurs in the same cycle, overflow stays 1 (set wins).
  - addr 3: 0x0000.
- Simultaneous push and pop: both happen, count unchanged. Push eligibility uses pre-cycle count, so a full FIFO accepts no push even when popped in the same cycle.
- count width is log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- irq = (count != 0), registered, mirrors count.

Test Plan:
- Reset, then buttons_in=0x00 held 20 cycles -> count stays 0, irq=0; addr 1 read returns 0x0000.
- Reset, then buttons_in=0x04 from cycle 0 -> within 8 cycles count=1, irq=1; addr 1 read returns 0xC002; following addr 2 read returns 0x0000.
- Reset, then buttons_in 0x00->0x81 and back to 0x00 after 20 cycles -> pops return, in order, 0xC000, 0xC007, then 0x8000, 0x8007 (press and release of buttons 0 and 7).
- Reset, then toggle button 3 high and low within 2 cycles, right after scan_idx passes 3 -> no event queued, count=0.
- Reset, FIFO_DEPTH=8, then generate 10 transitions with no reads -> count=8, addr 2 read returns 0x8008; next addr 2 read returns 0x0008; after 8 pops the 2 delayed events appear.
- Reset, then fill FIFO to 8 and assert reset with rd_en=1 on addr 1 -> next cycle rd_data=0, count=0, irq=0, overflow=0.
